// File: rtl/robs_div_pkg.sv
// Shared types and sizing for the robs_div restoring signed divider.
package robs_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned DEF_CNT_W = $clog2(DEF_WIDTH + 1);

endpackage

// File: rtl/robs_div_step.sv
// One restoring division step: shift {R,Q} left, trial-subtract |divisor|, set quotient bit.
module div_step
  import robs_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH+1:0] r_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH+1:0] trial;

  always_comb begin
    r_sh  = {r_i, q_i[WIDTH-1]};
    q_sh  = {q_i[WIDTH-2:0], 1'b0};
    trial = r_sh - {2'b00, dvs_i};
    r_o   = r_sh[WIDTH:0];
    q_o   = q_sh;
    if (!trial[WIDTH+1]) begin
      r_o = trial[WIDTH:0];
      q_o = {q_sh[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/robs_div.sv
// Sequential signed 2W/W divider with start/done handshake.
// Optional macro DIV_ERR_EARLY_EN: divide-by-zero and early overflow skip the iterations.
module robs_div
  import robs_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 done,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned CNT_W = cnt_width(WIDTH);

  localparam logic [WIDTH-1:0] Q_POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_NEG_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q;
  logic [DW-1:0]    dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sgn_q_q;
  logic             sgn_r_q;
  logic [WIDTH:0]   part_r_q;
  logic [WIDTH-1:0] part_q_q;
  logic [WIDTH-1:0] abs_dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dbz_q;
  logic             ovf_pre_q;

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             done_q;
  logic             dbz_out_q;
  logic             ovf_out_q;

  logic [DW-1:0]    abs_dvd;
  logic [WIDTH-1:0] abs_dvs;
  logic [WIDTH-1:0] dvd_hi;
  logic [WIDTH-1:0] dvd_lo;
  logic             dbz_d;
  logic             ovf_pre_d;

  logic [WIDTH:0]   step_r;
  logic [WIDTH-1:0] step_q;

  logic [WIDTH-1:0] q_signed;
  logic [WIDTH-1:0] r_signed;
  logic             ovf_d;

  // Operand magnitudes and early error detection, used in LOAD.
  always_comb begin
    abs_dvd   = dvd_q[DW-1] ? -dvd_q : dvd_q;
    abs_dvs   = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
    dvd_hi    = abs_dvd[DW-1:WIDTH];
    dvd_lo    = abs_dvd[WIDTH-1:0];
    dbz_d     = (dvs_q == '0);
    ovf_pre_d = (dvd_hi >= abs_dvs) && !dbz_d;
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_i   (part_r_q),
    .q_i   (part_q_q),
    .dvs_i (abs_dvs_q),
    .r_o   (step_r),
    .q_o   (step_q)
  );

  // Sign restoration and late overflow check, used in FIX.
  always_comb begin
    q_signed = sgn_q_q ? -part_q_q : part_q_q;
    r_signed = sgn_r_q ? -part_r_q[WIDTH-1:0] : part_r_q[WIDTH-1:0];
    ovf_d    = ovf_pre_q
             | (!sgn_q_q && (part_q_q > Q_POS_MAX))
             | ( sgn_q_q && (part_q_q > Q_NEG_MAG));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      sgn_q_q   <= 1'b0;
      sgn_r_q   <= 1'b0;
      part_r_q  <= '0;
      part_q_q  <= '0;
      abs_dvs_q <= '0;
      cnt_q     <= '0;
      dbz_q     <= 1'b0;
      ovf_pre_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            dvd_q     <= dividend;
            dvs_q     <= divisor;
            sgn_q_q   <= dividend[DW-1] ^ divisor[WIDTH-1];
            sgn_r_q   <= dividend[DW-1];
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            ovf_out_q <= 1'b0;
            state_q   <= S_LOAD;
          end else if (state_q == S_DONE) begin
            done_q <= 1'b1;
          end
        end

        S_LOAD: begin
          part_r_q  <= {1'b0, dvd_hi};
          part_q_q  <= dvd_lo;
          abs_dvs_q <= abs_dvs;
          cnt_q     <= '0;
          dbz_q     <= dbz_d;
          ovf_pre_q <= ovf_pre_d;
`ifdef DIV_ERR_EARLY_EN
          state_q   <= (dbz_d || ovf_pre_d) ? S_FIX : S_ITER;
`else
          state_q   <= S_ITER;
`endif
        end

        S_ITER: begin
          part_r_q <= step_r;
          part_q_q <= step_q;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end
        end

        S_FIX: begin
          // Divide-by-zero takes priority: its all-ones quotient would otherwise look like overflow.
          if (dbz_q) begin
            quo_q     <= '1;
            rem_q     <= dvd_q[WIDTH-1:0];
            dbz_out_q <= 1'b1;
            ovf_out_q <= 1'b0;
          end else if (ovf_d) begin
            quo_q     <= sgn_q_q ? Q_NEG_MAG : Q_POS_MAX;
            rem_q     <= '0;
            dbz_out_q <= 1'b0;
            ovf_out_q <= 1'b1;
          end else begin
            quo_q     <= q_signed;
            rem_q     <= r_signed;
            dbz_out_q <= 1'b0;
            ovf_out_q <= 1'b0;
          end
          state_q <= S_DONE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign done        = done_q;
  assign div_by_zero = dbz_out_q;
  assign overflow    = ovf_out_q;

endmodule

// File: tb/tb_robs_div.sv
// Self-checking bench for robs_div: directed vector table, corner sequences, random vs. arithmetic model.
module tb_robs_div;

  localparam int unsigned W       = 8;
  localparam int          MAX_LAT = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        done;
  logic        div_by_zero;
  logic        overflow;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  robs_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        z;
    logic        o;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: integer division truncates toward zero, % follows the dividend's sign.
  task automatic model(input logic [15:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic z, output logic o);
    int sa, sb, iq, ir;
    sa = int'($signed(a));
    sb = int'($signed(b));
    z  = 1'b0;
    o  = 1'b0;
    if (sb == 0) begin
      q = 8'hFF;
      r = a[7:0];
      z = 1'b1;
    end else begin
      iq = sa / sb;
      ir = sa % sb;
      if (iq > 127 || iq < -128) begin
        o = 1'b1;
        q = (iq > 0) ? 8'h7F : 8'h80;
        r = 8'h00;
      end else begin
        q = 8'(iq);
        r = 8'(ir);
      end
    end
  endtask

  function automatic int exp_lat(input logic [15:0] a, input logic [7:0] b);
`ifdef DIV_ERR_EARLY_EN
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
    if (sb == 0 || sa >= sb * 256) return 3;
`endif
    return int'(W) + 3;
  endfunction

  // Counts edges after the accepting edge until done is seen; caller is #1 past an edge.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!done && lat < MAX_LAT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int lat, output logic d0);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    d0    = done;
    wait_done(0, lat);
  endtask

  task automatic run_and_check(input string tag, input logic [15:0] a, input logic [7:0] b,
                               input logic [7:0] eq, input logic [7:0] er,
                               input logic ez, input logic eo);
    int   lat;
    logic d0;
    run_op(a, b, lat, d0);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat(a, b)));
    check({tag, "_q"},   32'(quotient),    32'(eq));
    check({tag, "_r"},   32'(remainder),   32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    check({tag, "_ovf"}, 32'(overflow),    32'(eo));
  endtask

  initial begin
    int          lat;
    logic        d0;
    logic [15:0] ra;
    logic [7:0]  rb, mq, mr;
    logic        mz, mo;

    vecs[0]  = '{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0};
    vecs[1]  = '{16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0};
    vecs[2]  = '{16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0};
    vecs[3]  = '{16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0};
    vecs[4]  = '{16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0};
    vecs[5]  = '{16'h4000, 8'h02, 8'h7F, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{16'hFF00, 8'h02, 8'h80, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{16'h0100, 8'h02, 8'h7F, 8'h00, 1'b0, 1'b1};
    vecs[8]  = '{16'h8000, 8'h80, 8'h7F, 8'h00, 1'b0, 1'b1};
    vecs[9]  = '{16'h0000, 8'hF9, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{16'h8000, 8'hFF, 8'h7F, 8'h00, 1'b0, 1'b1};

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(done),        32'(0));
    check("rst_q",    32'(quotient),    32'(0));
    check("rst_r",    32'(remainder),   32'(0));
    check("rst_dbz",  32'(div_by_zero), 32'(0));
    check("rst_ovf",  32'(overflow),    32'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                    vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].o);
      if (i == 0) begin
        repeat (3) @(posedge clk);
        #1;
        check("hold_done", 32'(done),     32'(1));
        check("hold_q",    32'(quotient), 32'(8'h0E));
        check("hold_r",    32'(remainder), 32'(8'h02));
      end
    end

    // Reset mid-operation must abort and clear every output.
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'h0064;
    divisor  = 8'h07;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_done", 32'(done),        32'(0));
    check("midrst_q",    32'(quotient),    32'(0));
    check("midrst_r",    32'(remainder),   32'(0));
    check("midrst_dbz",  32'(div_by_zero), 32'(0));
    check("midrst_ovf",  32'(overflow),    32'(0));
    @(negedge clk);
    reset = 1'b0;
    run_and_check("after_rst", 16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0);

    // Start pulse while iterating must be ignored.
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'h0064;
    divisor  = 8'h07;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'h1234;
    divisor  = 8'h03;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    wait_done(5, lat);
    check("busy_lat", 32'(lat),       32'(W + 3));
    check("busy_q",   32'(quotient),  32'(8'h0E));
    check("busy_r",   32'(remainder), 32'(8'h02));

    // Back-to-back restart from DONE.
    run_op(16'hFFF9, 8'h02, lat, d0);
    check("b2b_drop", 32'(d0),        32'(0));
    check("b2b_lat",  32'(lat),       32'(W + 3));
    check("b2b_q",    32'(quotient),  32'(8'hFD));
    check("b2b_r",    32'(remainder), 32'(8'hFF));

    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 4))
        0: begin ra = 16'($urandom); rb = 8'($urandom); end
        1: begin ra = 16'($signed(12'($urandom))); rb = 8'($urandom); end
        2: begin ra = 16'($urandom); rb = 8'h00; end
        default: begin ra = 16'($signed(14'($urandom))); rb = 8'($urandom_range(64, 191)); end
      endcase
      model(ra, rb, mq, mr, mz, mo);
      run_and_check($sformatf("rnd%0d_%h_%h", i, ra, rb), ra, rb, mq, mr, mz, mo);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/robs_div.md
Name: robs_div

Overview:
- Sequential signed divider: the inverse companion to the team's Robertson's multiplier.
- Divides a 2W-bit two's-complement dividend by a W-bit two's-complement divisor.
- Produces a W-bit quotient (truncated toward zero) and a W-bit remainder (sign follows the dividend).
- Uses the same start/done style as the multiplier so both arithmetic units sit behind the same top-level test harness.

Parameters:
- WIDTH, 8: divisor/quotient/remainder width; dividend is 2*WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launches a division; sampled only in IDLE or DONE.
- dividend  input  2*WIDTH  signed dividend; captured when start is accepted.
- divisor  input  WIDTH  signed divisor; captured when start is accepted.
- quotient  output  WIDTH  signed quotient; valid while done=1.
- remainder  output  WIDTH  signed remainder; valid while done=1.
- done  output  1  result valid; held until the next accepted start.
- div_by_zero  output  1  divisor was 0; valid while done=1.
- overflow  output  1  quotient not representable in WIDTH signed bits; valid while done=1.

Behaviour:
- Reset (synchronous, active-high, one clock):
  - FSM goes to IDLE.
  - quotient, remainder, done, div_by_zero and overflow all become 0.
  - Reset asserted mid-operation aborts the operation; no partial result is ever exposed.
- FSM states: IDLE, LOAD, ITER, FIX, DONE.
- IDLE: start=1 captures dividend/divisor and records sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend) -> LOAD.
- LOAD (1 cycle):
  - Forms unsigned magnitudes |dividend| (2W bits, so -2^(2W-1) is representable) and |divisor| (W bits).
  - Initialises partial remainder R (W+1 bits) = |dividend|[2W-1:W] and Q = |dividend|[W-1:0]; clears the iteration counter.
  - Flags dbz = (divisor==0).
  - Flags ovf_pre = (|dividend|[2W-1:W] >= |divisor|) and !dbz.
  - Next state -> ITER.
- ITER (exactly WIDTH cycles), one restoring step per cycle:
  - Shift {R,Q} left by 1.
  - Trial T = R - |divisor|.
  - If T is non-negative: R=T, Q[0]=1; else Q[0]=0.
  - After the WIDTH-th step -> FIX.
- FIX (1 cycle):
  - Apply sign_q to Q and sign_r to R[W-1:0].
  - ovf = ovf_pre, or (sign_q=0 and Q > 2^(W-1)-1), or (sign_q=1 and Q > 2^(W-1)).
  - Register outputs, then -> DONE.
- Result overrides:
  - dbz: quotient = all ones, remainder = dividend[W-1:0], div_by_zero=1, overflow=0.
  - ovf: quotient = 2^(W-1)-1 if sign_q=0, else -2^(W-1); remainder = 0; overflow=1.
- DONE:
  - done=1; outputs held stable.
  - start=1 recaptures operands -> LOAD; done, div_by_zero and overflow clear on that same edge.
- Latency: done rises on the (WIDTH+3)th rising edge after the edge that accepted start; 11 cycles for WIDTH=8. Latency is constant regardless of operands unless DIV_ERR_EARLY_EN is defined.
- Start while in LOAD/ITER/FIX: ignored; operands are not re-sampled.
- Arithmetic:
  - -2^(W-1) quotient is legal (e.g. -256/2 = -128).
  - Remainder magnitude is < |divisor|, so it always fits in W signed bits.
  - Zero dividend gives a zero remainder of positive sign.

Optional Feature:
- Macro: DIV_ERR_EARLY_EN.
- Defined: when dbz or ovf_pre is detected in LOAD, the FSM skips ITER and goes LOAD -> FIX. done rises on the 3rd edge after start, with the same override values as above.
- Undefined: error cases run the full WIDTH iterations; latency is always WIDTH+3.

Decomposition:
- Package robs_pkg holds:
  - state enum (IDLE, LOAD, ITER, FIX, DONE);
  - localparam for default WIDTH;
  - iteration counter width $clog2(WIDTH+1).
- Sub-module div_step (combinational): one restoring step.
  - Inputs: R, Q, |divisor|.
  - Outputs: next R, next Q.
  - Instantiated once inside robs_div.

Test Plan:
1. dividend=16'h0064 (100), divisor=8'h07 -> quotient=8'h0E, remainder=8'h02, flags 0; done on edge 11; done holds until next start.
2. Sign mix:
   - -100/7 -> q=8'hF2, r=8'hFE.
   - 100/-7 -> q=8'hF2, r=8'h02.
   - -100/-7 -> q=8'h0E, r=8'hFE.
3. divisor=0, dividend=16'h1234 -> div_by_zero=1, quotient=8'hFF, remainder=8'h34, overflow=0. Done on edge 11, or edge 3 with DIV_ERR_EARLY_EN.
4. Overflow and range boundaries:
   - 16'h4000/2 -> overflow=1, q=8'h7F, r=0.
   - 16'hFF00/2 -> q=8'h80, no overflow.
   - 16'h0100/2 -> overflow=1, q=8'h7F.
   - 16'h8000/8'h80 -> overflow=1, q=8'h7F.
5. Reset and busy handling:
   - Start 100/7, assert reset on cycle 5 -> next edge done=0 and all outputs 0.
   - A fresh start then completes normally.
   - Start pulses during ITER are ignored.
6. Back-to-back: hold start=1 in DONE with new operands 16'hFFF9/8'h02 -> done drops next edge; 11 edges later q=8'hFD, r=8'hFF.
